// File: rtl/data_mem_hs.sv
// Data memory for the LSU with valid/ready request and response handshakes.
// Latency: o_rsp_valid rises ReadLatency cycles after request acceptance.
// Backpressure: one request in flight; o_req_ready low until the response is taken.

package rv_pkg;
  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HWORD = 2'd1,
    WORD  = 2'd2
  } mem_op_sz_e;
endpackage

module data_mem_hs
  import rv_pkg::*;
#(
  parameter int DepthWords  = 1024,
  parameter int ReadLatency = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  mem_op_sz_e  i_mem_size,
  input  logic        i_unsigned,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int          AW    = $clog2(DepthWords);
  localparam int          CW    = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;
  localparam logic [32:0] BYTES = 33'(DepthWords) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic        r_we, r_uns, r_err;
  logic [31:0] r_addr, r_wdata, r_rdata;
  mem_op_sz_e  r_size;
  logic [31:0] r_mem [DepthWords];

  logic        w_accept, w_enter_resp;
  logic        w_we, w_uns, w_misal, w_range, w_inval, w_err, w_commit;
  logic [31:0] w_addr, w_wdata, w_word, w_shift, w_load, w_wdat;
  mem_op_sz_e  w_size;
  logic [32:0] w_size_bytes;
  logic [3:0]  w_be;
  logic [AW-1:0] w_idx;

  // State register; async reset discards any in-flight request
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_accept = 1'b1;
          if (ReadLatency > 1) begin
            w_next = S_WAIT;
          end else begin
            w_next       = S_RESP;
            w_enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Counter holds the remaining wait cycles; the last one moves to RESP
        if (r_cnt <= CW'(1)) begin
          w_next       = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // With single-cycle latency the access happens on the accept edge, so use live inputs then
  always_comb begin
    w_we    = w_accept ? i_we       : r_we;
    w_uns   = w_accept ? i_unsigned : r_uns;
    w_addr  = w_accept ? i_addr     : r_addr;
    w_wdata = w_accept ? i_wdata    : r_wdata;
    w_size  = w_accept ? i_mem_size : r_size;
  end

  // Error classification, lane steering and load extension
  always_comb begin
    w_size_bytes = 33'd4;
    w_inval      = 1'b0;
    w_misal      = 1'b0;
    w_be         = 4'b0000;
    w_wdat       = 32'h0;
    w_load       = 32'h0;
    w_idx        = w_addr[AW+1:2];
    w_word       = r_mem[w_idx];
    w_shift      = w_word >> {w_addr[1:0], 3'b000};
    case (w_size)
      BYTE: begin
        w_size_bytes = 33'd1;
        w_be         = 4'b0001 << w_addr[1:0];
        w_wdat       = {4{w_wdata[7:0]}};
        w_load       = {{24{~w_uns & w_shift[7]}}, w_shift[7:0]};
      end
      HWORD: begin
        w_size_bytes = 33'd2;
        w_misal      = w_addr[0];
        w_be         = 4'b0011 << w_addr[1:0];
        w_wdat       = {2{w_wdata[15:0]}};
        w_load       = {{16{~w_uns & w_shift[15]}}, w_shift[15:0]};
      end
      WORD: begin
        w_misal = |w_addr[1:0];
        w_be    = 4'b1111;
        w_wdat  = w_wdata;
        w_load  = w_shift;
      end
      default: w_inval = 1'b1;
    endcase
    // Any byte of the access beyond the top of memory is out of range
    w_range  = {1'b0, w_addr} > (BYTES - w_size_bytes);
    w_err    = w_inval | w_misal | w_range;
    // Qualify with reset so a request presented during reset never writes
    w_commit = w_enter_resp & w_we & ~w_err & i_rst;
  end

  // Request latch, latency counter and registered response
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_size  <= BYTE;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= i_we;
        r_uns   <= i_unsigned;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_size  <= i_mem_size;
        r_cnt   <= CW'(ReadLatency - 1);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'h0 : w_load;
      end else if (r_state == S_RESP && i_rsp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= 32'h0;
      end
    end
  end

  // Storage array, not reset; byte-lane writes keep untouched bytes intact
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs with ReadLatency=2 and ReadLatency=4 instances.
// Vector table for data/error/latency, plus backpressure and mid-flight reset sequences.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
module tb_data_mem_hs;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst2, rst4;
  logic        req_valid2, req_valid4;
  logic        req_ready2, req_ready4;
  logic        we, uns, rsp_ready;
  logic [31:0] addr, wdata;
  mem_op_sz_e  size;
  logic        rsp_valid2, rsp_valid4, err2, err4;
  logic [31:0] rdata2, rdata4;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  data_mem_hs #(.DepthWords(1024), .ReadLatency(2)) u_l2 (
    .i_clk(clk), .i_rst(rst2), .i_req_valid(req_valid2), .o_req_ready(req_ready2),
    .i_we(we), .i_addr(addr), .i_wdata(wdata), .i_mem_size(size), .i_unsigned(uns),
    .o_rsp_valid(rsp_valid2), .i_rsp_ready(rsp_ready), .o_rdata(rdata2), .o_err(err2)
  );

  data_mem_hs #(.DepthWords(1024), .ReadLatency(4)) u_l4 (
    .i_clk(clk), .i_rst(rst4), .i_req_valid(req_valid4), .o_req_ready(req_ready4),
    .i_we(we), .i_addr(addr), .i_wdata(wdata), .i_mem_size(size), .i_unsigned(uns),
    .o_rsp_valid(rsp_valid4), .i_rsp_ready(rsp_ready), .o_rdata(rdata4), .o_err(err4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Issue one request, wait (bounded) for the response, consume it with rsp_ready high.
  // Inputs are scrambled after acceptance to show they are ignored.
  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input bit u,
                     output logic [31:0] rd, output logic er, output int lat);
    we = w; addr = a; wdata = wd; size = mem_op_sz_e'(sz); uns = u;
    if (d == 2) req_valid2 = 1'b1; else req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid2 = 1'b0; req_valid4 = 1'b0;
    we = ~w; addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD; size = BYTE; uns = ~u;
    lat = 1;
    while (!((d == 2) ? rsp_valid2 : rsp_valid4) && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = (d == 2) ? rdata2 : rdata4;
    er = (d == 2) ? err2 : err4;
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    bit          u;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] hold_rd;
    logic        hold_er;

    rst2 = 1'b0; rst4 = 1'b0; req_valid2 = 1'b0; req_valid4 = 1'b0;
    we = 1'b0; uns = 1'b0; rsp_ready = 1'b1; addr = 32'h0; wdata = 32'h0; size = WORD;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'h0, req_ready2}, 32'd1);
    chk("reset_rsp_valid", {31'h0, rsp_valid2}, 32'd0);
    chk("reset_rdata",     rdata2, 32'h0);
    chk("reset_err",       {31'h0, err2}, 32'd0);
    rst2 = 1'b1; rst4 = 1'b1;
    @(posedge clk); #1;

    vecs = '{
      '{"sw_10",      1, 32'h010, 32'hDEADBEEF, 2'd2, 0, 32'h0,        0},
      '{"lw_10",      0, 32'h010, 32'h0,        2'd2, 0, 32'hDEADBEEF, 0},
      '{"lb_13",      0, 32'h013, 32'h0,        2'd0, 0, 32'hFFFFFFDE, 0},
      '{"lbu_13",     0, 32'h013, 32'h0,        2'd0, 1, 32'h000000DE, 0},
      '{"lh_12",      0, 32'h012, 32'h0,        2'd1, 0, 32'hFFFFDEAD, 0},
      '{"lhu_10",     0, 32'h010, 32'h0,        2'd1, 1, 32'h0000BEEF, 0},
      '{"sb_11",      1, 32'h011, 32'hAAAAAA5A, 2'd0, 0, 32'h0,        0},
      '{"lw_after_sb",0, 32'h010, 32'h0,        2'd2, 0, 32'hDEAD5AEF, 0},
      '{"lw_mis_11",  0, 32'h011, 32'h0,        2'd2, 0, 32'h0,        1},
      '{"sw_mis_11",  1, 32'h011, 32'h11111111, 2'd2, 0, 32'h0,        1},
      '{"lw_after_mis",0,32'h010, 32'h0,        2'd2, 0, 32'hDEAD5AEF, 0},
      '{"sw_ffc",     1, 32'hFFC, 32'h80AABBCC, 2'd2, 0, 32'h0,        0},
      '{"lw_ffe_err", 0, 32'hFFE, 32'h0,        2'd2, 0, 32'h0,        1},
      '{"lb_fff",     0, 32'hFFF, 32'h0,        2'd0, 0, 32'hFFFFFF80, 0},
      '{"lhu_ffe",    0, 32'hFFE, 32'h0,        2'd1, 1, 32'h000080AA, 0},
      '{"lh_fff_mis", 0, 32'hFFF, 32'h0,        2'd1, 0, 32'h0,        1},
      '{"lw_1000_oor",0, 32'h1000,32'h0,        2'd2, 0, 32'h0,        1},
      '{"lb_1000_oor",0, 32'h1000,32'h0,        2'd0, 1, 32'h0,        1},
      '{"ld_inval",   0, 32'h010, 32'h0,        2'd3, 0, 32'h0,        1},
      '{"st_inval",   1, 32'h010, 32'h0,        2'd3, 0, 32'h0,        1},
      '{"sh_12",      1, 32'h012, 32'hFFFF1234, 2'd1, 0, 32'h0,        0},
      '{"lw_after_sh",0, 32'h010, 32'h0,        2'd2, 0, 32'h12345AEF, 0}
    };

    foreach (vecs[i]) begin
      txn(2, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].sz, vecs[i].u, rd, er, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_err"}, {31'h0, er}, {31'h0, vecs[i].exp_err});
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'd2);
    end

    // Response backpressure: hold rsp_ready low for 5 cycles
    rsp_ready = 1'b0;
    we = 1'b0; addr = 32'h010; size = WORD; uns = 1'b0; req_valid2 = 1'b1;
    @(posedge clk); #1;
    req_valid2 = 1'b0; addr = 32'h0;
    lat = 1;
    while (!rsp_valid2 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd2);
    hold_rd = rdata2;
    hold_er = err2;
    chk("bp_rdata", hold_rd, 32'h12345AEF);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'h0, rsp_valid2}, 32'd1);
      chk("bp_hold_rdata", rdata2, 32'h12345AEF);
      chk("bp_hold_err",   {31'h0, err2}, {31'h0, hold_er});
      chk("bp_hold_ready", {31'h0, req_ready2}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'h0, rsp_valid2}, 32'd0);
    chk("bp_release_ready", {31'h0, req_ready2}, 32'd1);

    // ReadLatency=4: preload zero, then reset during WAIT of a store
    txn(4, 1, 32'h020, 32'h0, 2'd2, 0, rd, er, lat);
    chk("l4_preload_latency", 32'(lat), 32'd4);
    chk("l4_preload_err", {31'h0, er}, 32'd0);
    we = 1'b1; addr = 32'h020; wdata = 32'h12345678; size = WORD; req_valid4 = 1'b1;
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    chk("l4_wait_ready", {31'h0, req_ready4}, 32'd0);
    @(posedge clk); #1;
    rst4 = 1'b0;
    #1;
    chk("l4_rst_ready", {31'h0, req_ready4}, 32'd1);
    chk("l4_rst_valid", {31'h0, rsp_valid4}, 32'd0);
    chk("l4_rst_rdata", rdata4, 32'h0);
    chk("l4_rst_err",   {31'h0, err4}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("l4_rst_no_rsp", {31'h0, rsp_valid4}, 32'd0);
    rst4 = 1'b1;
    @(posedge clk); #1;
    txn(4, 0, 32'h020, 32'h0, 2'd2, 0, rd, er, lat);
    chk("l4_lw_after_rst", rd, 32'h0);
    chk("l4_lw_after_rst_err", {31'h0, er}, 32'd0);
    chk("l4_lw_latency", 32'(lat), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
Parametrised data memory with a valid/ready request and response handshake for the CPU load/store unit. Supports byte, halfword and word accesses, with sign- or zero-extended loads. Adds configurable access latency, misalignment and range error reporting, and response backpressure, so slower backing storage can replace the single-cycle memory without changing the LSU interface.

Parameters:
DepthWords, 1024, memory size in 32-bit words; byte capacity = DepthWords*4; must be a power of two.
ReadLatency, 1, cycles from request acceptance to o_rsp_valid; must be >= 1.

Ports:
i_clk  in  1  clock; all state updates on rising edge.
i_rst  in  1  reset; asynchronous, active-low.
i_req_valid  in  1  request present.
o_req_ready  out  1  block can accept a request.
i_we  in  1  1 = store, 0 = load.
i_addr  in  32  byte address.
i_wdata  in  32  store data; low byte/halfword used for narrow stores.
i_mem_size  in  mem_op_sz_e  BYTE / HWORD / WORD (rv_pkg).
i_unsigned  in  1  load zero-extends when 1 and sign-extends when 0; ignored for stores.
o_rsp_valid  out  1  response present.
i_rsp_ready  in  1  consumer accepts response.
o_rdata  out  32  load result; 0 for stores and errors.
o_err  out  1  response flags an error (misaligned, out of range, or invalid size).

Behaviour:
- Reset: state IDLE, o_req_ready=1, o_rsp_valid=0, o_rdata=0, o_err=0, latency counter=0. Memory array is not cleared; contents after reset are undefined.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: o_req_ready=1. On i_req_valid&&o_req_ready, latch we, addr, wdata, size and unsigned. Load counter with ReadLatency-1. Go to WAIT if ReadLatency>1, else RESP.
  - WAIT: o_req_ready=0. Decrement counter each cycle; go to RESP when counter reaches 0.
  - RESP: o_rsp_valid=1; o_rdata and o_err stay stable. On i_rsp_ready, go to IDLE and drop o_rsp_valid the next cycle.
- Timing: o_rsp_valid rises exactly ReadLatency cycles after the acceptance edge.
- Throughput: one outstanding request at most; o_req_ready=0 in WAIT and RESP.
  - Minimum spacing between requests is ReadLatency+1 cycles when i_rsp_ready is held high.
  - There is no same-cycle bypass from RESP to the next acceptance.
- Error checks, evaluated on latched fields:
  - misaligned: HWORD with addr[0]!=0, or WORD with addr[1:0]!=0.
  - out of range: addr > DepthWords*4 - size_bytes, so a partial overlap at the top of memory is an error.
  - invalid: i_mem_size not BYTE/HWORD/WORD.
  - Any error: o_err=1, o_rdata=0, no memory write.
- Store commit: memory is written on the edge that enters RESP, little-endian, with only the addressed bytes modified. Store response carries o_rdata=0.
- Load data: read on the edge that enters RESP, little-endian.
  - BYTE: bits[7:0] = byte at addr.
  - HWORD: {addr+1, addr}.
  - WORD: {addr+3..addr}.
  - Bits above the access width are filled with the MSB of the loaded value when i_unsigned=0, else zeros.
- Reset mid-operation: an in-flight request is discarded; a store in WAIT is not committed; a response in RESP is lost.
- Inputs are ignored outside the acceptance cycle; changes to i_addr, i_wdata, etc. during WAIT or RESP have no effect.

Test Plan:
- ReadLatency=2: SW 0xDEADBEEF @0x10, then LW @0x10 → o_rsp_valid exactly 2 cycles after acceptance, o_rdata=0xDEADBEEF, o_err=0.
- After the above: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB 0x5A @0x11, then LW @0x10 → 0xDEAD5AEF (other bytes unchanged).
- LW @0x11 → o_err=1, o_rdata=0. SW @0x11 followed by LW @0x10 → data unchanged. With DepthWords=1024, LW @0xFFE → o_err=1, and LB @0xFFF → o_err=0.
- Backpressure: hold i_rsp_ready=0 for 5 cycles → o_rsp_valid, o_rdata and o_err stay stable and o_req_ready=0. Raise i_rsp_ready → next cycle IDLE, o_req_ready=1.
- ReadLatency=4: accept SW 0x12345678 @0x20, assert i_rst=0 during WAIT → outputs return to reset values immediately. After release, LW @0x20 does not return 0x12345678 (preload 0 before the sequence).
